// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with RAW forwarding and operand selection for the ula.
// Optional feature macro: OPERAND_FORWARD_EN (undefined = no forwarding, operands from register file only).
module ex_operand_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [4:0]            id_shamt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [3:0]            id_alu_op,
  input  logic                  id_alu_src_imm,
  input  logic                  id_shift_src_shamt,
  input  logic                  id_reg_write,
  input  logic                  id_dst_rt,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]     exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]     memwb_result,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     alu_in1,
  output logic [DATA_W-1:0]     alu_in2,
  output logic [3:0]            alu_op,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  ex_reg_write,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel
);

  localparam logic [1:0] SEL_REG   = 2'd0;
  localparam logic [1:0] SEL_MEMWB = 2'd1;
  localparam logic [1:0] SEL_EXMEM = 2'd2;

  logic                  valid_q;
  logic                  reg_write_q;
  logic                  alu_src_imm_q;
  logic                  shift_src_shamt_q;
  logic [3:0]            alu_op_q;
  logic [4:0]            shamt_q;
  logic [REG_ADDR_W-1:0] rs_q;
  logic [REG_ADDR_W-1:0] rt_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [DATA_W-1:0]     rs_data_q;
  logic [DATA_W-1:0]     rt_data_q;
  logic [DATA_W-1:0]     imm_q;

  logic [DATA_W-1:0]     operand_a;
  logic [DATA_W-1:0]     operand_b;
  logic                  is_shift;

  // reset and flush both produce an all-zero bubble; stall simply holds
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      valid_q           <= 1'b0;
      reg_write_q       <= 1'b0;
      alu_src_imm_q     <= 1'b0;
      shift_src_shamt_q <= 1'b0;
      alu_op_q          <= 4'b0000;
      shamt_q           <= 5'd0;
      rs_q              <= '0;
      rt_q              <= '0;
      dest_q            <= '0;
      rs_data_q         <= '0;
      rt_data_q         <= '0;
      imm_q             <= '0;
    end else if (!stall) begin
      valid_q           <= id_valid;
      reg_write_q       <= id_reg_write & id_valid;
      alu_src_imm_q     <= id_alu_src_imm;
      shift_src_shamt_q <= id_shift_src_shamt;
      alu_op_q          <= id_alu_op;
      shamt_q           <= id_shamt;
      rs_q              <= id_rs;
      rt_q              <= id_rt;
      dest_q            <= id_dst_rt ? id_rt : id_rd;
      rs_data_q         <= id_rs_data;
      rt_data_q         <= id_rt_data;
      imm_q             <= id_imm;
    end
  end

`ifdef OPERAND_FORWARD_EN
  // EX/MEM is the younger result, so it is checked first; $0 never forwards
  always_comb begin
    fwd_a_sel = SEL_REG;
    fwd_b_sel = SEL_REG;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_q))
      fwd_a_sel = SEL_EXMEM;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_q))
      fwd_a_sel = SEL_MEMWB;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_q))
      fwd_b_sel = SEL_EXMEM;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_q))
      fwd_b_sel = SEL_MEMWB;
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{exmem_reg_write, exmem_rd, exmem_result,
                               memwb_reg_write, memwb_rd, memwb_result};
  assign fwd_a_sel = SEL_REG;
  assign fwd_b_sel = SEL_REG;
`endif

  always_comb begin
    case (fwd_a_sel)
      SEL_EXMEM: operand_a = exmem_result;
      SEL_MEMWB: operand_a = memwb_result;
      default:   operand_a = rs_data_q;
    endcase
    case (fwd_b_sel)
      SEL_EXMEM: operand_b = exmem_result;
      SEL_MEMWB: operand_b = memwb_result;
      default:   operand_b = rt_data_q;
    endcase
  end

  always_comb begin
    case (alu_op_q)
      4'b0100, 4'b0101, 4'b1101, 4'b1000, 4'b1001, 4'b1010: is_shift = 1'b1;
      default:                                              is_shift = 1'b0;
    endcase
  end

  // the ula always shifts In1 by In2[4:0], so shifts put the rt value on In1
  always_comb begin
    if (is_shift) begin
      alu_in1 = operand_b;
      alu_in2 = shift_src_shamt_q ? {{(DATA_W-5){1'b0}}, shamt_q} : operand_a;
    end else begin
      alu_in1 = operand_a;
      alu_in2 = alu_src_imm_q ? imm_q : operand_b;
    end
  end

  assign alu_op        = alu_op_q;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_dest       = dest_q;
  assign ex_store_data = operand_b;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: reference model checked every cycle plus directed literals.
module tb_ex_operand_stage;

`ifdef OPERAND_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_alu_src_imm, id_shift_src_shamt, id_reg_write, id_dst_rt;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid, ex_reg_write;
  logic [31:0] alu_in1, alu_in2, ex_store_data;
  logic [3:0]  alu_op;
  logic [4:0]  ex_dest;
  logic [1:0]  fwd_a_sel, fwd_b_sel;

  int passed = 0;
  int total  = 0;

  ex_operand_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_alu_src_imm(id_alu_src_imm),
    .id_shift_src_shamt(id_shift_src_shamt), .id_reg_write(id_reg_write),
    .id_dst_rt(id_dst_rt), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
    .memwb_rd(memwb_rd), .memwb_result(memwb_result), .ex_valid(ex_valid),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
  );

  always #5 clock = ~clock;

  // Reference model: the instruction currently sitting in EX
  typedef struct {
    logic        valid, rw, imm_sel, sh_sel;
    logic [4:0]  rs, rt, dest, shamt;
    logic [3:0]  op;
    logic [31:0] rs_data, rt_data, imm;
  } instr_t;

  instr_t cur;
  bit     model_ok = 1'b0;

  function automatic instr_t bubble();
    instr_t b;
    b = '{valid: 1'b0, rw: 1'b0, imm_sel: 1'b0, sh_sel: 1'b0, rs: 5'd0, rt: 5'd0,
          dest: 5'd0, shamt: 5'd0, op: 4'd0, rs_data: 32'd0, rt_data: 32'd0, imm: 32'd0};
    return b;
  endfunction

  always @(posedge clock) begin
    if (reset || flush) begin
      cur      = bubble();
      model_ok = model_ok | reset;
    end else if (!stall) begin
      cur.valid   = id_valid;
      cur.rw      = id_valid && id_reg_write;
      cur.imm_sel = id_alu_src_imm;
      cur.sh_sel  = id_shift_src_shamt;
      cur.rs      = id_rs;
      cur.rt      = id_rt;
      cur.dest    = id_dst_rt ? id_rt : id_rd;
      cur.shamt   = id_shamt;
      cur.op      = id_alu_op;
      cur.rs_data = id_rs_data;
      cur.rt_data = id_rt_data;
      cur.imm     = id_imm;
    end
  end

  // Value of register r as seen by EX: youngest in-flight writer wins, $0 is never forwarded
  function automatic logic [31:0] read_reg(input logic [4:0] r, input logic [31:0] rf, output logic [1:0] src);
    src = 2'd0;
    if (!FWD || r == 5'd0) return rf;
    if (exmem_reg_write && exmem_rd == r) begin src = 2'd2; return exmem_result; end
    if (memwb_reg_write && memwb_rd == r) begin src = 2'd1; return memwb_result; end
    return rf;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle
  always @(negedge clock) begin
    if (model_ok) begin
      logic [31:0] a, b, e1, e2;
      logic [1:0]  sa, sb;
      a = read_reg(cur.rs, cur.rs_data, sa);
      b = read_reg(cur.rt, cur.rt_data, sb);
      if (cur.op inside {4'b0100, 4'b0101, 4'b1101, 4'b1000, 4'b1001, 4'b1010}) begin
        e1 = b;
        e2 = cur.sh_sel ? 32'(cur.shamt) : a;
      end else begin
        e1 = a;
        e2 = cur.imm_sel ? cur.imm : b;
      end
      checkOutput("m_in1",   alu_in1, e1);
      checkOutput("m_in2",   alu_in2, e2);
      checkOutput("m_op",    32'(alu_op), 32'(cur.op));
      checkOutput("m_valid", 32'(ex_valid), 32'(cur.valid));
      checkOutput("m_rw",    32'(ex_reg_write), 32'(cur.rw));
      checkOutput("m_dest",  32'(ex_dest), 32'(cur.dest));
      checkOutput("m_store", ex_store_data, b);
      checkOutput("m_fwda",  32'(fwd_a_sel), 32'(sa));
      checkOutput("m_fwdb",  32'(fwd_b_sel), 32'(sb));
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs, rt, rd, input logic [31:0] rsd, rtd, imm,
                               input logic [3:0] op, input logic [4:0] sh, input logic imm_s, sh_s, rw, dst_rt);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alu_op = op; id_shamt = sh;
    id_alu_src_imm = imm_s; id_shift_src_shamt = sh_s; id_reg_write = rw; id_dst_rt = dst_rt;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
    // add $3,$1,$2 presented during reset
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 4'b0010, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) cycle();
    checkOutput("rst_valid", 32'(ex_valid), 32'd0);
    checkOutput("rst_rw",    32'(ex_reg_write), 32'd0);
    checkOutput("rst_op",    32'(alu_op), 32'd0);
    checkOutput("rst_in1",   alu_in1, 32'd0);
    checkOutput("rst_in2",   alu_in2, 32'd0);

    reset = 1'b0;
    cycle();
    checkOutput("add_in1",  alu_in1, 32'd5);
    checkOutput("add_in2",  alu_in2, 32'd7);
    checkOutput("add_op",   32'(alu_op), 32'b0010);
    checkOutput("add_dest", 32'(ex_dest), 32'd3);
    checkOutput("add_fwda", 32'(fwd_a_sel), 32'd0);
    checkOutput("add_fwdb", 32'(fwd_b_sel), 32'd0);

    exmem_reg_write = 1'b1; exmem_rd = 5'd1; exmem_result = 32'd100;
    memwb_reg_write = 1'b1; memwb_rd = 5'd1; memwb_result = 32'd200;
    cycle();
    checkOutput("fwd_ex_in1",  alu_in1, FWD ? 32'd100 : 32'd5);
    checkOutput("fwd_ex_sel",  32'(fwd_a_sel), FWD ? 32'd2 : 32'd0);
    checkOutput("fwd_ex_st",   ex_store_data, 32'd7);
    exmem_rd = 5'd0;
    #1;
    checkOutput("fwd_wb_in1",  alu_in1, FWD ? 32'd200 : 32'd5);
    checkOutput("fwd_wb_sel",  32'(fwd_a_sel), FWD ? 32'd1 : 32'd0);

    // write to $0 must never forward
    exmem_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'h0000_FFFF;
    applyStimulus(1'b1, 5'd0, 5'd2, 5'd3, 32'd0, 32'd7, 32'd0, 4'b0010, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    checkOutput("r0_in1", alu_in1, 32'd0);
    checkOutput("r0_sel", 32'(fwd_a_sel), 32'd0);
    memwb_reg_write = 1'b0;

    // sll $4,$2,3
    applyStimulus(1'b1, 5'd0, 5'd2, 5'd4, 32'd0, 32'h1, 32'd0, 4'b0100, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle();
    checkOutput("sll_in1", alu_in1, 32'h1);
    checkOutput("sll_in2", alu_in2, 32'd3);

    // srav: shift amount from rs
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd6, 32'd4, 32'h8000_0000, 32'd0, 4'b1010, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    checkOutput("srav_in1", alu_in1, 32'h8000_0000);
    checkOutput("srav_in2", alu_in2, 32'd4);

    // addi $5,$1,-16: immediate on In2, destination rt
    applyStimulus(1'b1, 5'd1, 5'd5, 5'd9, 32'h10, 32'h33, 32'hFFFF_FFF0, 4'b0010, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle();
    checkOutput("addi_in2",  alu_in2, 32'hFFFF_FFF0);
    checkOutput("addi_dest", 32'(ex_dest), 32'd5);
    checkOutput("addi_st",   ex_store_data, 32'h33);

    // stall for 3 cycles while ID changes; forwarding still tracks downstream
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'(7 + i), 5'd8, 5'(10 + i), 32'hDEAD_0000 + 32'(i), 32'h1234, 32'd1,
                    4'b0110, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      if (i == 1) begin exmem_reg_write = 1'b1; exmem_rd = 5'd1; exmem_result = 32'h55; end
      else exmem_reg_write = 1'b0;
      cycle();
      checkOutput("stall_dest", 32'(ex_dest), 32'd5);
      checkOutput("stall_op",   32'(alu_op), 32'b0010);
      checkOutput("stall_in1",  alu_in1, (FWD && i == 1) ? 32'h55 : 32'h10);
    end
    exmem_reg_write = 1'b0;

    flush = 1'b1;
    cycle();
    checkOutput("flush_valid", 32'(ex_valid), 32'd0);
    checkOutput("flush_rw",    32'(ex_reg_write), 32'd0);
    checkOutput("flush_op",    32'(alu_op), 32'd0);
    flush = 1'b0; stall = 1'b0;

    // invalid slot with reg_write set must not write
    applyStimulus(1'b0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 4'b0010, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    checkOutput("inv_rw",    32'(ex_reg_write), 32'd0);
    checkOutput("inv_valid", 32'(ex_valid), 32'd0);

    repeat (2) cycle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
ID/EX pipeline register plus operand-select and forwarding logic that directly feeds the ula inputs In1, In2 and OP.
- Captures decoded instruction fields each cycle.
- Resolves RAW hazards against the EX/MEM and MEM/WB stages.
- Performs the shift-operand swap so the ula always computes "In1 shifted by In2[4:0]".

Parameters:
DATA_W, 32, datapath width
REG_ADDR_W, 5, register-file address width

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall  input  1  hold the stage contents (hazard unit)
flush  input  1  replace the captured instruction with a bubble
id_valid  input  1  the ID slot holds a real instruction
id_rs_data  input  DATA_W  register-file read port A
id_rt_data  input  DATA_W  register-file read port B
id_imm  input  DATA_W  immediate, already sign/zero-extended by decode
id_shamt  input  5  instruction shamt field
id_rs, id_rt, id_rd  input  REG_ADDR_W each  register specifiers
id_alu_op  input  4  ula opcode, same encoding as the ula
id_alu_src_imm  input  1  In2 takes the immediate (non-shift ops)
id_shift_src_shamt  input  1  shifts take shamt; otherwise rs value
id_reg_write  input  1  instruction writes the register file
id_dst_rt  input  1  destination is rt (I-type); otherwise rd
exmem_reg_write  input  1  EX/MEM writes the register file
exmem_rd  input  REG_ADDR_W  EX/MEM destination register
exmem_result  input  DATA_W  EX/MEM ALU result
memwb_reg_write  input  1  MEM/WB writes the register file
memwb_rd  input  REG_ADDR_W  MEM/WB destination register
memwb_result  input  DATA_W  MEM/WB writeback value
ex_valid  output  1  EX slot holds a real instruction
alu_in1  output  DATA_W  to ula In1
alu_in2  output  DATA_W  to ula In2
alu_op  output  4  to ula OP
ex_store_data  output  DATA_W  forwarded rt value, for stores
ex_dest  output  REG_ADDR_W  resolved destination register
ex_reg_write  output  1  registered reg_write, gated by ex_valid
fwd_a_sel  output  2  rs source: 0 = register, 1 = MEM/WB, 2 = EX/MEM
fwd_b_sel  output  2  rt source, same encoding

Behaviour:
- Sequential, all updates on the rising edge of clock. Priority: reset > flush > stall > load.
- reset: all stage registers cleared; ex_valid=0, ex_reg_write=0, alu_op=4'b0000, ex_dest=0, captured data=0. With no forwarding match, alu_in1=alu_in2=ex_store_data=0.
- flush: the next state is a bubble with valid=0, reg_write=0, alu_op=0 and all fields 0. flush overrides stall in the same cycle.
- stall (without flush): every stage register holds its value. Forwarding remains combinational on the held fields, so the forwarded operands track the downstream stages.
- load: the stage captures all id_* inputs.
  - ex_dest = id_dst_rt ? id_rt : id_rd.
  - ex_reg_write = id_reg_write & id_valid.
- Latency: ID fields drive the ula one cycle after capture. Forwarding adds zero cycles.
- Forwarding is combinational and evaluated against the registered rs and rt.
  - Match condition: writer reg_write=1, writer rd != 0, and rd equals the specifier.
  - EX/MEM wins over MEM/WB when both match.
  - Register 0 is never forwarded; it always reads the registered value, which the register file supplies as 0.
- Operand A = forwarded rs value; operand B = forwarded rt value. ex_store_data = operand B.
- Shift ops (alu_op 0100, 0101, 1101, 1000, 1001, 1010):
  - alu_in1 = operand B (the rt value).
  - alu_in2 = shift_src_shamt ? {27'b0, shamt} : operand A.
- All other ops: alu_in1 = operand A; alu_in2 = alu_src_imm ? imm : operand B.
- alu_op is the registered id_alu_op passed through unchanged; it is forced to 0 in a bubble.
- A bubble still drives operands, but the results are don't-care because ex_reg_write=0.

Optional Feature:
OPERAND_FORWARD_EN
- Defined: forwarding as described above.
- Undefined: fwd_a_sel and fwd_b_sel are tied to 0 and operands come only from the registered register-file values. Software or the hazard unit must cover RAW distances below 3.
- Port list is identical in both builds.

Test Plan:
- Reset asserted for 2 cycles while id_valid=1 -> ex_valid=0, ex_reg_write=0, alu_op=0, alu_in1=alu_in2=0.
- add $3,$1,$2 with rs_data=5, rt_data=7, no matches -> next cycle alu_in1=5, alu_in2=7, alu_op=0010, ex_dest=3, fwd_a_sel=fwd_b_sel=0.
- Same add with exmem(rw=1, rd=1, result=100) and memwb(rw=1, rd=1, result=200) -> alu_in1=100, fwd_a_sel=2. Change exmem_rd to 0 -> alu_in1=200, fwd_a_sel=1.
- Write to $0: memwb(rw=1, rd=0, result=0xFFFF), rs=0, rs_data=0 -> alu_in1=0, fwd_a_sel=0.
- sll $4,$2,3 (rt_data=0x1, shift_src_shamt=1, op=0100) -> alu_in1=0x1, alu_in2=3.
- srav (op=1010) with rs_data=4, rt_data=0x80000000 -> alu_in1=0x80000000, alu_in2=4.
- Stall for 3 cycles while the id_* inputs change, then flush together with stall -> contents held during the stall. After the flush: ex_valid=0, ex_reg_write=0, alu_op=0.
